// File: rtl/dmem_bytelane_if.sv
// Request/response bundle between the load/store unit and the byte-lane data memory.
// master = load/store unit side, slave = memory side.
interface dmem_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bytelane.sv
// MIPS data memory with byte/half/word lanes, misalignment detection,
// configurable response latency and a zero-fill sweep after reset.
module dmem_bytelane #(
    parameter int ADDR_WIDTH = 6,
    parameter int LATENCY    = 1,
    parameter int BIG_ENDIAN = 1
) (
    input logic            clk,
    input logic            reset,
    dmem_bytelane_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clrIdx_q, clrIdx_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [31:0]           pendData_q, pendData_d;
    logic                  pendErr_q, pendErr_d;
    logic                  rspValid_q, rspValid_d;
    logic [31:0]           rspRdata_q, rspRdata_d;
    logic                  rspErr_q, rspErr_d;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [1:0]            byteOff;
    logic [1:0]            lane;
    logic                  misaligned;
    logic                  accept;
    logic [3:0]            byteEn;
    logic [31:0]           wrData;
    logic [31:0]           rdWord;
    logic [31:0]           shifted;
    logic [31:0]           loadResult;
    logic                  unusedAddrBits;

    assign wordIdx        = bus.req_addr[ADDR_WIDTH+1:2];
    assign byteOff        = bus.req_addr[1:0];
    assign unusedAddrBits = ^bus.req_addr[31:ADDR_WIDTH+2];
    assign accept         = (state_q == IDLE) && bus.req_valid;
    assign rdWord         = mem[wordIdx];
    assign shifted        = rdWord >> {lane, 3'b000};

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = rspValid_q;
    assign bus.rsp_rdata  = rspRdata_q;
    assign bus.rsp_err    = rspErr_q;

    // lane is the index of the least-significant byte touched by the access
    always_comb begin
        lane       = 2'd0;
        byteEn     = 4'b0000;
        wrData     = bus.req_wdata;
        misaligned = 1'b0;
        loadResult = 32'd0;
        case (bus.req_size)
            2'b00: begin
                lane       = (BIG_ENDIAN != 0) ? ~byteOff : byteOff;
                byteEn     = 4'b0001 << lane;
                wrData     = {4{bus.req_wdata[7:0]}};
                loadResult = bus.req_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                            : {24'd0, shifted[7:0]};
            end
            2'b01: begin
                lane       = (BIG_ENDIAN != 0) ? {~byteOff[1], 1'b0} : {byteOff[1], 1'b0};
                byteEn     = 4'b0011 << lane;
                wrData     = {2{bus.req_wdata[15:0]}};
                misaligned = byteOff[0];
                loadResult = bus.req_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                            : {16'd0, shifted[15:0]};
            end
            2'b10: begin
                byteEn     = 4'b1111;
                misaligned = (byteOff != 2'b00);
                loadResult = rdWord;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
        if (misaligned || bus.req_we) begin
            loadResult = 32'd0;
        end
    end

    // Storage: zero sweep during CLEAR, lane-masked store at the acceptance edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[clrIdx_q] <= 32'd0;
            end else if (accept && bus.req_we && !misaligned) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteEn[b]) begin
                        mem[wordIdx][b*8 +: 8] <= wrData[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clrIdx_d   = clrIdx_q;
        cnt_d      = cnt_q;
        pendData_d = pendData_q;
        pendErr_d  = pendErr_q;
        rspValid_d = 1'b0;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        case (state_q)
            CLEAR: begin
                clrIdx_d = clrIdx_q + 1'b1;
                if (clrIdx_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (accept) begin
                    pendData_d = loadResult;
                    pendErr_d  = misaligned;
                    // With single-cycle latency the response is registered at acceptance
                    if (LATENCY == 1) begin
                        rspValid_d = 1'b1;
                        rspRdata_d = loadResult;
                        rspErr_d   = misaligned;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 2'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b1;
                    rspRdata_d = pendData_q;
                    rspErr_d   = pendErr_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clrIdx_q   <= '0;
            cnt_q      <= 2'd0;
            pendData_q <= 32'd0;
            pendErr_q  <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= 32'd0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clrIdx_q   <= clrIdx_d;
            cnt_q      <= cnt_d;
            pendData_q <= pendData_d;
            pendErr_q  <= pendErr_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end
endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: a big-endian LATENCY=1 instance (A)
// and a little-endian LATENCY=3 instance (B) sharing clock and reset.
module tb_dmem_bytelane;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
        string       tag;
    } expT;

    logic clk;
    logic reset;
    int   cyc;
    int   nChecks;
    int   nPass;
    int   nFail;
    int   strayRsp;
    int   lastWait;
    expT  qA[$];
    expT  qB[$];

    dmem_bytelane_if ifA ();
    dmem_bytelane_if ifB ();

    dmem_bytelane #(.ADDR_WIDTH(6), .LATENCY(LAT_A), .BIG_ENDIAN(1)) dutA (
        .clk(clk), .reset(reset), .bus(ifA)
    );
    dmem_bytelane #(.ADDR_WIDTH(6), .LATENCY(LAT_B), .BIG_ENDIAN(0)) dutB (
        .clk(clk), .reset(reset), .bus(ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input expT e, input logic [31:0] obsData, input logic obsErr, input int obsCyc);
        check32({e.tag, ".rdata"}, obsData, e.data);
        check32({e.tag, ".err"}, {31'd0, obsErr}, {31'd0, e.err});
        check32({e.tag, ".cycle"}, 32'(obsCyc), 32'(e.due));
    endtask

    // Scoreboard monitors: every response pops the oldest expectation of its instance
    always @(negedge clk) begin : monA
        expT e;
        if (!reset && ifA.rsp_valid) begin
            if (qA.size() == 0) strayRsp++;
            else begin
                e = qA.pop_front();
                checkOutput(e, ifA.rsp_rdata, ifA.rsp_err, cyc);
            end
        end
    end

    always @(negedge clk) begin : monB
        expT e;
        if (!reset && ifB.rsp_valid) begin
            if (qB.size() == 0) strayRsp++;
            else begin
                e = qB.pop_front();
                checkOutput(e, ifB.rsp_rdata, ifB.rsp_err, cyc);
            end
        end
    end

    function automatic logic readyOf(input int d);
        return (d == 0) ? ifA.req_ready : ifB.req_ready;
    endfunction

    task automatic driveReq(input int d, input logic v, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        if (d == 0) begin
            ifA.req_valid = v; ifA.req_we = we; ifA.req_size = size;
            ifA.req_signed = sgn; ifA.req_addr = addr; ifA.req_wdata = wdata;
        end else begin
            ifB.req_valid = v; ifB.req_we = we; ifB.req_size = size;
            ifB.req_signed = sgn; ifB.req_addr = addr; ifB.req_wdata = wdata;
        end
    endtask

    // Holds the request until ready, then records the expectation keyed to the accept edge
    task automatic applyStimulus(input int d, input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr, input string tag);
        expT e;
        int  waited;
        @(negedge clk);
        driveReq(d, 1'b1, we, size, sgn, addr, wdata);
        waited = 0;
        while (!readyOf(d) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        lastWait = waited;
        if (waited >= 300) begin
            check32({tag, ".readyTimeout"}, {31'd0, readyOf(d)}, 32'd1);
            driveReq(d, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);
            return;
        end
        @(posedge clk);
        #1;
        driveReq(d, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);
        e.data = expData;
        e.err  = expErr;
        e.due  = cyc + ((d == 0) ? LAT_A : LAT_B) - 1;
        e.tag  = tag;
        if (d == 0) qA.push_back(e);
        else qB.push_back(e);
    endtask

    task automatic st(input int d, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic expErr, input string tag);
        applyStimulus(d, 1'b1, size, 1'b0, addr, wdata, 32'd0, expErr, tag);
    endtask

    task automatic ld(input int d, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                      input logic [31:0] expData, input logic expErr, input string tag);
        applyStimulus(d, 1'b0, size, sgn, addr, 32'd0, expData, expErr, tag);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((qA.size() != 0 || qB.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check32("drain", 32'(qA.size() + qB.size()), 32'd0);
    endtask

    // Called #1 after the last reset edge; counts not-ready cycles until the sweep ends
    task automatic waitClear(input string tag);
        int low;
        int seen;
        low  = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifA.rsp_valid || ifB.rsp_valid) seen++;
            if (ifA.req_ready) break;
            low++;
        end
        check32({tag, ".readyLowCycles"}, 32'(low), 32'd64);
        check32({tag, ".readyA"}, {31'd0, ifA.req_ready}, 32'd1);
        check32({tag, ".readyB"}, {31'd0, ifB.req_ready}, 32'd1);
        check32({tag, ".rspDuringClear"}, 32'(seen), 32'd0);
    endtask

    initial begin
        expT dropped;
        cyc = 0; nChecks = 0; nPass = 0; nFail = 0; strayRsp = 0; lastWait = 0;
        reset = 1'b1;
        driveReq(0, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);
        driveReq(1, 1'b0, 1'b0, SZ_W, 1'b0, 32'd0, 32'd0);

        repeat (3) @(negedge clk);
        check32("reset.ready", {31'd0, ifA.req_ready}, 32'd0);
        check32("reset.rspValid", {31'd0, ifA.rsp_valid}, 32'd0);
        check32("reset.rdata", ifA.rsp_rdata, 32'd0);
        check32("reset.err", {31'd0, ifB.rsp_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        waitClear("clear1");

        ld(0, SZ_W, 1'b0, 32'h0000_002C, 32'h0000_0000, 1'b0, "A.lwCleared");
        ld(1, SZ_W, 1'b0, 32'h0000_003C, 32'h0000_0000, 1'b0, "B.lwCleared");

        st(0, SZ_W, 32'h10, 32'hDEAD_BEEF, 1'b0, "A.sw10");
        ld(0, SZ_B, 1'b1, 32'h10, 32'hFFFF_FFDE, 1'b0, "A.lb10");
        ld(0, SZ_B, 1'b0, 32'h13, 32'h0000_00EF, 1'b0, "A.lbu13");
        ld(0, SZ_H, 1'b1, 32'h12, 32'hFFFF_BEEF, 1'b0, "A.lh12");
        ld(0, SZ_H, 1'b0, 32'h10, 32'h0000_DEAD, 1'b0, "A.lhu10");
        st(0, SZ_B, 32'h11, 32'h0000_005A, 1'b0, "A.sb11");
        ld(0, SZ_W, 1'b0, 32'h10, 32'hDE5A_BEEF, 1'b0, "A.lwAfterSb");
        st(0, SZ_H, 32'h10, 32'h0000_CAFE, 1'b0, "A.sh10");
        ld(0, SZ_W, 1'b0, 32'h10, 32'hCAFE_BEEF, 1'b0, "A.lwAfterSh");

        st(0, SZ_W, 32'h20, 32'h1122_3344, 1'b0, "A.sw20");
        st(0, SZ_H, 32'h21, 32'h0000_AAAA, 1'b1, "A.shMis21");
        st(0, SZ_W, 32'h22, 32'h5555_5555, 1'b1, "A.swMis22");
        st(0, SZ_R, 32'h20, 32'h7777_7777, 1'b1, "A.stRsv");
        ld(0, SZ_W, 1'b0, 32'h20, 32'h1122_3344, 1'b0, "A.lwUnchanged");
        ld(0, SZ_R, 1'b0, 32'h20, 32'h0000_0000, 1'b1, "A.ldRsv");
        ld(0, SZ_H, 1'b1, 32'h23, 32'h0000_0000, 1'b1, "A.lhMis23");
        ld(0, SZ_B, 1'b0, 32'h23, 32'h0000_0044, 1'b0, "A.lbu23");

        st(0, SZ_W, 32'h100, 32'h1234_5678, 1'b0, "A.swWrap");
        ld(0, SZ_W, 1'b0, 32'h0, 32'h1234_5678, 1'b0, "A.lwWrap");
        ld(0, SZ_W, 1'b0, 32'hFFFF_FF10, 32'hCAFE_BEEF, 1'b0, "A.lwUpperIgnored");

        waitDrain();
        st(1, SZ_W, 32'h10, 32'hDEAD_BEEF, 1'b0, "B.sw10");
        check32("B.firstWait", 32'(lastWait), 32'd0);
        st(1, SZ_B, 32'h11, 32'h0000_005A, 1'b0, "B.sb11");
        check32("B.readyLow1", 32'(lastWait), 32'd2);
        ld(1, SZ_W, 1'b0, 32'h10, 32'hDEAD_5AEF, 1'b0, "B.lwAfterSb");
        check32("B.readyLow2", 32'(lastWait), 32'd2);
        ld(1, SZ_B, 1'b1, 32'h10, 32'hFFFF_FFEF, 1'b0, "B.lb10");
        check32("B.readyLow3", 32'(lastWait), 32'd2);
        ld(1, SZ_H, 1'b0, 32'h12, 32'h0000_DEAD, 1'b0, "B.lhu12");
        ld(1, SZ_H, 1'b0, 32'h11, 32'h0000_0000, 1'b1, "B.lhMis11");
        waitDrain();

        // Abort a B load mid-flight: its response must never appear
        ld(1, SZ_W, 1'b0, 32'h10, 32'hDEAD_5AEF, 1'b0, "B.aborted");
        dropped = qB.pop_back();
        @(negedge clk);
        check32("abort.busy", {31'd0, ifB.req_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        waitClear("clear2");

        ld(0, SZ_W, 1'b0, 32'h0, 32'h0000_0000, 1'b0, "A.lw0AfterReset");
        ld(0, SZ_W, 1'b0, 32'h10, 32'h0000_0000, 1'b0, "A.lw10AfterReset");
        ld(1, SZ_W, 1'b0, 32'h10, 32'h0000_0000, 1'b0, "B.lw10AfterReset");
        waitDrain();
        repeat (5) @(negedge clk);
        check32("strayResponses", 32'(strayRsp), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
